// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the signed 7-segment scan driver.
//   SEG_BLANK / SEG_MINUS : active-low special glyphs (bit 6 = g ... bit 0 = a)
//   HEX_GLYPH             : active-low glyphs for hex digits 0..F
//   idx_width()           : width of a digit index that counts 0..num_dig
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Packed table, so HEX_GLYPH[n] selects the glyph for nibble n.
  // The concatenation is listed from entry 15 down to entry 0.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1011000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Bits needed for an index that takes the values 0..num_dig
  // (num_dig magnitude digits plus the sign digit).
  function automatic int idx_width(input int num_dig);
    return $clog2(num_dig + 1);
  endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// -----------------------------------------------------------------------------
// seg7_hex_glyph
// Combinational hex nibble to active-low 7-segment glyph lookup.
//   nibble : 4-bit hex digit
//   glyph  : active-low segments, glyph[6] = g ... glyph[0] = a
// -----------------------------------------------------------------------------
module seg7_hex_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_signed.sv
// -----------------------------------------------------------------------------
// seg7_scan_signed
// Time-multiplexed driver for a signed hex value on a common-anode 7-segment
// array. It scans NUM_DIG magnitude digits plus one sign digit, and each digit
// slot starts with one all-dark cycle so that no ghosting occurs.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : captures value / signed_mode / lz_blank together
//   value        : DATA_W-bit value to display
//   signed_mode  : 1 = two's complement, 0 = unsigned
//   lz_blank     : 1 = blank leading zero digits (digit 0 always shown)
//   seg          : active-low segments, seg[6] = g ... seg[0] = a
//   an           : active-low one-hot digit enable, an[NUM_DIG] = sign digit
// -----------------------------------------------------------------------------
module seg7_scan_signed
  import seg7_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  input  logic                  signed_mode,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic [DATA_W/4:0]     an
);

  localparam int NUM_DIG = DATA_W / 4;
  localparam int IDX_W   = idx_width(NUM_DIG);
  localparam int DIV_W   = $clog2(SCAN_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_SIGN = IDX_W'(NUM_DIG);

  // Latched display request
  logic [DATA_W-1:0] val_q;
  logic              signed_q;
  logic              blank_q;

  // Scan state
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Output registers
  logic [6:0]        seg_q;
  logic [NUM_DIG:0]  an_q;

  // Sign-magnitude view of the latched value
  logic              neg;
  logic [DATA_W-1:0] mag;
  logic [NUM_DIG-1:0] upper_zero;

  // Digit selection for the slot the output register is about to show
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic [6:0]        digit_seg;
  logic [NUM_DIG:0]  an_d;

  assign neg = signed_q & val_q[DATA_W-1];
  // Negation at DATA_W bits: the most-negative value maps onto itself, which
  // read as unsigned is exactly its magnitude.
  assign mag = neg ? (~val_q + DATA_W'(1)) : val_q;

  // upper_zero[k] is set when nibbles k..NUM_DIG-1 of the magnitude are all 0.
  always_comb begin
    logic zero_run;
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      zero_run      = zero_run & (mag[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_run;
    end
  end

  // Next divider / index. An index beyond the sign digit can only come from
  // corruption; it falls back to 0 straight away.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (idx_q > IDX_SIGN) begin
      idx_d = '0;
    end else if (div_q == DIV_LAST) begin
      idx_d = (idx_q == IDX_SIGN) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The output register is loaded from the next scan position, so seg/an
  // line up with div_q/idx_q: div_q == 0 is always the dark cycle.
  always_comb begin
    logic lz_hit;
    nibble    = '0;
    lz_hit    = 1'b0;
    digit_seg = SEG_BLANK;
    an_d      = '1;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nibble = mag[4*k +: 4];
        lz_hit = blank_q && (k != 0) && upper_zero[k];
      end
    end
    for (int k = 0; k <= NUM_DIG; k++) begin
      an_d[k] = (idx_d != IDX_W'(k));
    end
    if (idx_d == IDX_SIGN) begin
      digit_seg = neg ? SEG_MINUS : SEG_BLANK;
    end else if (idx_d < IDX_SIGN) begin
      digit_seg = lz_hit ? SEG_BLANK : glyph;
    end
  end

  seg7_hex_glyph u_glyph (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      signed_q <= 1'b0;
      blank_q  <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      div_q <= div_d;
      idx_q <= idx_d;
      if (load) begin
        val_q    <= value;
        signed_q <= signed_mode;
        blank_q  <= lz_blank;
      end
      if (div_d == '0) begin
        seg_q <= SEG_BLANK;
        an_q  <= '1;
      end else begin
        seg_q <= digit_seg;
        an_q  <= an_d;
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_signed.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_signed
// Self-checking bench for seg7_scan_signed (DATA_W = 16, SCAN_DIV = 4).
// A reference model predicts seg/an for every cycle from the display rules:
// sign-magnitude arithmetic, leading-zero rule, slot = cycle / SCAN_DIV.
// Directed cases exercise the listed corner values; random loads follow.
// -----------------------------------------------------------------------------
module tb_seg7_scan_signed;

  localparam int DATA_W   = 16;
  localparam int SCAN_DIV = 4;
  localparam int NUM_DIG  = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load;
  logic [DATA_W-1:0] value;
  logic              signed_mode;
  logic              lz_blank;
  logic [6:0]        seg;
  logic [NUM_DIG:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_signed #(
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .signed_mode (signed_mode),
    .lz_blank    (lz_blank),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] model_digit(input int k, input int v,
                                             input bit sgn, input bit lz);
    bit neg;
    int mag;
    neg = sgn && (v >= 32768);
    mag = neg ? (65536 - v) % 65536 : v;
    if (k == NUM_DIG) return neg ? 7'h3F : 7'h7F;
    if (lz && k > 0 && (mag >> (4 * k)) == 0) return 7'h7F;
    return glyph_tab[(mag >> (4 * k)) & 15];
  endfunction

  int         n_edge;
  int         m_val;
  bit         m_sgn, m_lz;
  logic [6:0] exp_seg;
  logic [4:0] exp_an;

  // Edge n after reset release shows slot n / SCAN_DIV, position n % SCAN_DIV,
  // using whatever request was captured at an earlier edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge  = 0;
      m_val   = 0;
      m_sgn   = 0;
      m_lz    = 0;
      exp_seg = 7'h7F;
      exp_an  = 5'h1F;
    end else begin
      int d;
      n_edge++;
      d = (n_edge / SCAN_DIV) % (NUM_DIG + 1);
      if (n_edge % SCAN_DIV == 0) begin
        exp_seg = 7'h7F;
        exp_an  = 5'h1F;
      end else begin
        exp_seg = model_digit(d, m_val, m_sgn, m_lz);
        exp_an  = 5'h1F & ~(5'h01 << d);
      end
      if (load) begin
        m_val = int'(value);
        m_sgn = signed_mode;
        m_lz  = lz_blank;
      end
    end
  end

  always @(negedge clk) begin
    check("seg_cycle", 32'(seg), 32'(exp_seg));
    check("an_cycle",  32'(an),  32'(exp_an));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [15:0] v, input bit s, input bit l);
    @(negedge clk);
    value       = v;
    signed_mode = s;
    lz_blank    = l;
    load        = 1'b1;
    @(negedge clk);
    load        = 1'b0;
  endtask

  // Returns at the first negedge where digit k is lit (bounded wait).
  task automatic wait_slot(input int k);
    bit         hit;
    logic [4:0] want;
    hit  = 0;
    want = ~(5'h01 << k);
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (an == want) hit = 1;
    end
    check($sformatf("slot%0d_reached", k), 32'(hit), 32'd1);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom);
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF - 16'($urandom_range(0, 20));
      4:       return 16'($urandom_range(0, 255));
      default: return 16'h7FFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] first_an [6] = '{5'h1F, 5'h1E, 5'h1E, 5'h1E, 5'h1F, 5'h1D};

    rst_n       = 1'b0;
    load        = 1'b0;
    value       = '0;
    signed_mode = 1'b0;
    lz_blank    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an",  32'(an),  32'h1F);

    // First slot after release: one dark cycle, then digit 0 for 3 cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("first_an%0d", i), 32'(an), 32'(first_an[i]));
    end

    // Unsigned 0x1234
    do_load(16'h1234, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    wait_slot(0); check("u1234_d0", 32'(seg), 32'h19);
    wait_slot(1); check("u1234_d1", 32'(seg), 32'h30);
    wait_slot(2); check("u1234_d2", 32'(seg), 32'h24);
    wait_slot(3); check("u1234_d3", 32'(seg), 32'h79);
    wait_slot(4); check("u1234_sg", 32'(seg), 32'h7F);

    // -5 with leading-zero blanking, then without
    do_load(16'hFFFB, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    wait_slot(0); check("m5lz_d0", 32'(seg), 32'h12);
    wait_slot(2); check("m5lz_d2", 32'(seg), 32'h7F);
    wait_slot(4); check("m5lz_sg", 32'(seg), 32'h3F);
    do_load(16'hFFFB, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    wait_slot(1); check("m5_d1", 32'(seg), 32'h40);
    wait_slot(3); check("m5_d3", 32'(seg), 32'h40);

    // Most-negative value, signed then unsigned
    do_load(16'h8000, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    wait_slot(0); check("mn_d0", 32'(seg), 32'h40);
    wait_slot(3); check("mn_d3", 32'(seg), 32'h00);
    wait_slot(4); check("mn_sg", 32'(seg), 32'h3F);
    do_load(16'h8000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    wait_slot(4); check("u8000_sg", 32'(seg), 32'h7F);

    // Load zero with blanking while digit 1 is lit
    do_load(16'h1234, 1'b0, 1'b0);
    wait_slot(1);
    do_load(16'h0000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    wait_slot(0); check("z_d0", 32'(seg), 32'h40);
    wait_slot(1); check("z_d1", 32'(seg), 32'h7F);

    // Asynchronous reset while digit 3 is lit
    do_load(16'hABCD, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    wait_slot(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_an",  32'(an),  32'h1F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rel_an", 32'(an), 32'h1F);
    wait_slot(0); check("rel_d0", 32'(seg), 32'h40);
    wait_slot(3); check("rel_d3", 32'(seg), 32'h40);

    // Random loads at random points in the scan, sometimes held for a while
    for (int t = 0; t < 250; t++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      @(negedge clk);
      value       = rand_val();
      signed_mode = 1'($urandom_range(0, 1));
      lz_blank    = 1'($urandom_range(0, 1));
      load        = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        value = rand_val();
      end
      @(negedge clk);
      load = 1'b0;
    end
    repeat (2 * (NUM_DIG + 1) * SCAN_DIV) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_signed.md
Name: seg7_scan_signed

Overview:
- Time-multiplexed driver for a signed hexadecimal value on a common-anode 7-segment array.
- Latches a DATA_W-bit value on a load strobe. In signed mode it converts two's complement to sign-magnitude.
- Scans NUM_DIG magnitude digits plus one sign digit, with optional leading-zero blanking and an anti-ghosting blank cycle between digits.
- Sits between the datapath result registers and the board display pins.

Parameters:
- DATA_W, 16, value width; must be a multiple of 4. NUM_DIG = DATA_W/4 is derived.
- SCAN_DIV, 50000, clock cycles per digit slot; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture strobe for value/signed_mode/lz_blank
- value  input  DATA_W  value to display
- signed_mode  input  1  1: two's complement; 0: unsigned
- lz_blank  input  1  1: blank leading zero digits
- seg  output  7  active-low segments, seg[6]=g … seg[0]=a
- an  output  NUM_DIG+1  active-low one-hot digit enable; an[NUM_DIG] is the sign digit, an[0] is the least significant hex digit

Behaviour:
- Clock and reset
  - Single clock domain. Reset is asynchronous and active-low.
- Reset state
  - Latched value = 0, mode = 0, blank flag = 0.
  - Divider = 0, digit index = 0.
  - seg = 7'b1111111, an = all ones.
- Load
  - When load=1 at a clk edge, value, signed_mode and lz_blank are latched together.
  - load held high re-latches every cycle.
  - No busy state; load is accepted in every cycle, including mid-scan.
- Magnitude
  - Unsigned mode: magnitude = latched value.
  - Signed mode with MSB=1: magnitude = two's-complement negation, computed at DATA_W bits as an unsigned result.
  - The most-negative value (e.g. 0x8000) yields magnitude 0x8000 and displays as "-8000".
  - Negative flag = signed_mode & MSB.
- Glyphs (active-low, g..a)
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1011000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - Minus = 0111111 (g only). Blank = 1111111.
- Sign digit
  - Shows minus if the negative flag is set, else blank.
  - Position is fixed and not affected by blanking.
- Leading-zero blanking
  - When the latched blank flag = 1, digit k (k ≥ 1) is blank iff magnitude nibbles k..NUM_DIG-1 are all zero.
  - Digit 0 is never blanked.
- Scan
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - Digit index advances 0,1,…,NUM_DIG,0 on each divider wrap.
  - Registered outputs, per divider count:
    - count = 0 (blank cycle): an = all ones, seg = blank.
    - counts 1..SCAN_DIV-1: an = one-hot low at the current index, seg = that digit's glyph.
  - Each digit is therefore lit for SCAN_DIV-1 cycles per SCAN_DIV-cycle slot. Full frame = (NUM_DIG+1)·SCAN_DIV cycles.
- Latency
  - seg/an are registered, so a load in cycle t is reflected on the active digit at edge t+2 (latch, then output register).
- Reset mid-scan
  - Outputs go to reset values immediately (asynchronous).
  - After release the scan restarts at index 0 with a blank cycle.
- Out-of-range index
  - Unreachable. The index register is limited to 0..NUM_DIG and returns to 0 if ever corrupted.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F and SEG_MINUS = 7'h3F.
  - The 16-entry hex glyph constant table.
  - The digit-index width function clog2(NUM_DIG+1).
- One natural sub-module, seg7_hex_glyph: combinational 4-bit to 7-bit glyph lookup using the package table.
- Divider, index, latch, negation and blanking logic stay in seg7_scan_signed.

Test Plan (DATA_W=16, SCAN_DIV=4):
- Reset: hold rst_n=0, toggle clk -> seg=0x7F, an=5'b11111. Release; the first slot is index 0: one cycle of an=11111, then 3 cycles of an=11110.
- Unsigned: load value=0x1234, signed_mode=0, lz_blank=0 -> per slot (index 0..4), seg values: 0x19, 0x30, 0x24, 0x79, 0x7F; an = 11110, 11101, 11011, 10111, 01111. Blank cycle between each.
- Signed negative with blanking: load 0xFFFB, signed_mode=1, lz_blank=1 -> digit0 = 0x12; digits1–3 = 0x7F; sign = 0x3F.
  - Same value with lz_blank=0 -> digits1–3 = 0x40.
- Most negative: load 0x8000, signed_mode=1 -> digit3 = 0x00 ('8'), digits0–2 = 0x40, sign = 0x3F.
  - Same value with signed_mode=0 -> sign = 0x7F.
- Mid-scan load and zero: while index 1 is lit, load 0x0000 with lz_blank=1 -> within 2 cycles seg = 0x7F on digit 1; on the next index-0 slot seg = 0x40.
- Reset mid-scan: assert rst_n=0 asynchronously during index 3 -> seg=0x7F and an=11111 before the next clk edge. After release, index 0 and the latched value reads back as 0 (display "0000").
